gpio_bus_slave: RTL and testbench

//  Bus-side responder for the GPIO peripheral at 0x4010_xxxx. The system bus

---
 rtl/gpio_bus_slave.sv | 153 +++++++++++++++
 tb/tb_gpio_bus_slave.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/gpio_bus_slave.sv
// gpio_bus_slave: bus responder for the GPIO peripheral window.
//   Holds DATA_OUT / DIR, synchronizes pin inputs into DATA_IN, and offers
//   SET / CLR / TGL aliases of DATA_OUT. Read data is registered (1-cycle latency).
//   Optional edge interrupt block is built when the macro GPIO_IRQ_EN is defined
//   (adds IRQ_MASK at 0x18, IRQ_STATUS at 0x1C, and the gpio_irq port).
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   gpio_ce               chip enable from the bus decoder, qualifies all strobes
//   bus_addr              byte address, only [7:2] decoded
//   bus_re, bus_we        read strobe, byte-lane write strobes
//   bus_wdata, bus_rdata  write data in, registered read data out
//   gpio_in               asynchronous pin inputs
//   gpio_out, gpio_oe     pin output values and output enables (1 = drive)
//   gpio_irq              level interrupt (GPIO_IRQ_EN only)
module gpio_bus_slave #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             gpio_ce,
    input  logic [31:0]      bus_addr,
    input  logic             bus_re,
    input  logic [3:0]       bus_we,
    input  logic [31:0]      bus_wdata,
    output logic [31:0]      bus_rdata,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe
`ifdef GPIO_IRQ_EN
    ,
    output logic             gpio_irq
`endif
);

    // Bits at or above WIDTH are never written, so they always read back as 0.
    localparam logic [31:0] ValidMask = {32{1'b1}} >> (32 - WIDTH);

    logic [5:0]       off;
    logic             rd;
    logic [31:0]      wmask;
    logic [31:0]      wbits;
    logic [31:0]      din;
    logic [31:0]      rd_mux;
    logic [31:0]      dout_q, dout_d;
    logic [31:0]      dir_q, dir_d;
    logic [31:0]      rdata_q;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];

    // Only bus_addr[7:2] is decoded; the rest alias the same registers.
    logic unused_addr;
    assign unused_addr = ^{bus_addr[31:8], bus_addr[1:0]};

    assign off = bus_addr[7:2];
    assign rd  = gpio_ce & bus_re;

    always_comb begin
        wmask = '0;
        for (int i = 0; i < 4; i++) begin
            wmask[8*i +: 8] = {8{gpio_ce & bus_we[i]}};
        end
        wmask = wmask & ValidMask;
        wbits = bus_wdata & wmask;
    end

    always_comb begin
        din = '0;
        din[WIDTH-1:0] = sync_q[SYNC_STAGES-1];
    end

`ifdef GPIO_IRQ_EN
    logic [31:0] mask_q, mask_d;
    logic [31:0] status_q, status_d;
    logic [31:0] prev_q;
    logic [31:0] rise;
    logic        irq_q;

    assign rise = din & ~prev_q;

    always_comb begin
        mask_d = mask_q;
        if (off == 6'h06) mask_d = (mask_q & ~wmask) | wbits;
        // W1C first, then OR in fresh edges so a coincident edge wins.
        status_d = status_q;
        if (off == 6'h07) status_d = status_q & ~wbits;
        status_d = status_d | rise;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q   <= '0;
            status_q <= '0;
            prev_q   <= '0;
            irq_q    <= 1'b0;
        end else begin
            mask_q   <= mask_d;
            status_q <= status_d;
            prev_q   <= din;
            irq_q    <= |(status_q & mask_q);
        end
    end

    assign gpio_irq = irq_q;
`endif

    always_comb begin
        dout_d = dout_q;
        dir_d  = dir_q;
        case (off)
            6'h00:   dout_d = (dout_q & ~wmask) | wbits;
            6'h01:   dir_d  = (dir_q & ~wmask) | wbits;
            6'h03:   dout_d = dout_q | wbits;
            6'h04:   dout_d = dout_q & ~wbits;
            6'h05:   dout_d = dout_q ^ wbits;
            default: ;
        endcase
    end

    // Read mux sees pre-write register values, so a same-cycle write is not visible.
    always_comb begin
        rd_mux = '0;
        case (off)
            6'h00:   rd_mux = dout_q;
            6'h01:   rd_mux = dir_q;
            6'h02:   rd_mux = din;
`ifdef GPIO_IRQ_EN
            6'h06:   rd_mux = mask_q;
            6'h07:   rd_mux = status_q;
`endif
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q  <= '0;
            dir_q   <= '0;
            rdata_q <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            dout_q <= dout_d;
            dir_q  <= dir_d;
            if (rd) rdata_q <= rd_mux;
            sync_q[0] <= gpio_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign bus_rdata = rdata_q;
    assign gpio_out  = dout_q[WIDTH-1:0];
    assign gpio_oe   = dir_q[WIDTH-1:0];

endmodule

// File: tb/tb_gpio_bus_slave.sv
module tb_gpio_bus_slave;

    localparam int unsigned WIDTH       = 32;
    localparam int unsigned SYNC_STAGES = 2;
    localparam logic [31:0] Base        = 32'h4010_0000;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             gpio_ce;
    logic [31:0]      bus_addr;
    logic             bus_re;
    logic [3:0]       bus_we;
    logic [31:0]      bus_wdata;
    logic [31:0]      bus_rdata;
    logic [WIDTH-1:0] gpio_in;
    logic [WIDTH-1:0] gpio_out;
    logic [WIDTH-1:0] gpio_oe;
`ifdef GPIO_IRQ_EN
    logic             gpio_irq;
`endif

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q [$];

    gpio_bus_slave #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .gpio_ce   (gpio_ce),
        .bus_addr  (bus_addr),
        .bus_re    (bus_re),
        .bus_we    (bus_we),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .gpio_in   (gpio_in),
        .gpio_out  (gpio_out),
        .gpio_oe   (gpio_oe)
`ifdef GPIO_IRQ_EN
        ,
        .gpio_irq  (gpio_irq)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        gpio_ce   = 1'b0;
        bus_re    = 1'b0;
        bus_we    = 4'h0;
        bus_wdata = '0;
        bus_addr  = '0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] data,
                      input logic ce = 1'b1);
        gpio_ce   = ce;
        bus_addr  = addr;
        bus_we    = we;
        bus_wdata = data;
        tick();
        idle();
    endtask

    // Expected data is queued at issue and compared when the registered data appears.
    task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        gpio_ce  = 1'b1;
        bus_addr = addr;
        bus_re   = 1'b1;
        exp_q.push_back(exp);
        tick();
        idle();
        chk(tag, bus_rdata, exp_q.pop_front());
    endtask

    initial begin
        idle();
        gpio_in = '0;
        rst_n   = 1'b0;

        // Reset with random activity on the inputs.
        for (int i = 0; i < 6; i++) begin
            gpio_ce   = 1'($urandom);
            bus_re    = 1'($urandom);
            bus_we    = 4'($urandom);
            bus_addr  = Base | 32'($urandom_range(0, 7) * 4);
            bus_wdata = $urandom;
            gpio_in   = $urandom;
            tick();
        end
        chk("rst_gpio_out", gpio_out, '0);
        chk("rst_gpio_oe", gpio_oe, '0);
        chk("rst_rdata", bus_rdata, '0);
        idle();
        gpio_in = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        rd("rst_read_data_out", Base, 32'h0);

        // Byte lanes.
        wr(Base + 32'h04, 4'b0101, 32'hFFFF_FFFF);
        chk("lane_gpio_oe", gpio_oe, 32'h00FF_00FF);
        rd("lane_read_dir", Base + 32'h04, 32'h00FF_00FF);
        rd("misaligned_dir", Base + 32'h06, 32'h00FF_00FF);

        // SET / CLR / TGL.
        wr(Base, 4'hF, 32'h0000_F0F0);
        chk("data_out_init", gpio_out, 32'h0000_F0F0);
        wr(Base + 32'h0C, 4'hF, 32'h0000_000F);
        chk("set", gpio_out, 32'h0000_F0FF);
        wr(Base + 32'h10, 4'hF, 32'h0000_F000);
        chk("clr", gpio_out, 32'h0000_00FF);
        wr(Base + 32'h14, 4'hF, 32'h0000_0101);
        chk("tgl", gpio_out, 32'h0000_01FE);
        wr(Base + 32'h0C, 4'b0010, 32'hFFFF_FFFF);
        chk("set_one_lane", gpio_out, 32'h0000_FFFE);
        rd("set_reads_zero", Base + 32'h0C, 32'h0);
        rd("alias_data_out", Base + 32'h0000_FF00, 32'h0000_FFFE);

        // Input synchronizer latency: visible only on a read issued SYNC_STAGES cycles later.
        gpio_in = 32'hA5;
        for (int k = 0; k <= SYNC_STAGES; k++) begin
            rd($sformatf("sync_k%0d", k), Base + 32'h08, (k == SYNC_STAGES) ? 32'hA5 : 32'h0);
        end

        // Strobes without gpio_ce are ignored.
        wr(Base, 4'hF, 32'h1234_5678, 1'b0);
        wr(Base + 32'h04, 4'hF, 32'hFFFF_FFFF, 1'b0);
        chk("gated_gpio_out", gpio_out, 32'h0000_FFFE);
        chk("gated_gpio_oe", gpio_oe, 32'h00FF_00FF);

        // Unmapped offset.
        wr(Base + 32'h20, 4'hF, 32'hDEAD_BEEF);
        rd("unmapped", Base + 32'h20, 32'h0);
        chk("unmapped_no_side_effect", gpio_out, 32'h0000_FFFE);

        // Read/write collision returns the pre-write value.
        wr(Base, 4'hF, 32'h11);
        gpio_ce   = 1'b1;
        bus_addr  = Base;
        bus_re    = 1'b1;
        bus_we    = 4'hF;
        bus_wdata = 32'h22;
        exp_q.push_back(32'h11);
        tick();
        idle();
        chk("collision_rdata", bus_rdata, exp_q.pop_front());
        rd("collision_after", Base, 32'h22);

`ifdef GPIO_IRQ_EN
        gpio_in = '0;
        for (int i = 0; i < 5; i++) tick();
        wr(Base + 32'h18, 4'hF, 32'h1);
        wr(Base + 32'h1C, 4'hF, 32'hFFFF_FFFF);
        tick();
        tick();
        chk("irq_idle", 32'(gpio_irq), 32'h0);
        gpio_in = 32'h1;
        for (int i = 0; i < SYNC_STAGES + 3; i++) tick();
        rd("irq_status_set", Base + 32'h1C, 32'h1);
        chk("irq_asserted", 32'(gpio_irq), 32'h1);
        rd("irq_mask", Base + 32'h18, 32'h1);
        // New rise coincident with W1C: the edge wins.
        gpio_in = '0;
        for (int i = 0; i < 5; i++) tick();
        gpio_in = 32'h1;
        for (int i = 0; i < SYNC_STAGES; i++) tick();
        wr(Base + 32'h1C, 4'hF, 32'h1);
        rd("irq_set_wins", Base + 32'h1C, 32'h1);
        // Clear alone.
        wr(Base + 32'h1C, 4'hF, 32'h1);
        tick();
        chk("irq_cleared", 32'(gpio_irq), 32'h0);
        rd("irq_status_clear", Base + 32'h1C, 32'h0);
`else
        wr(Base + 32'h18, 4'hF, 32'hFFFF_FFFF);
        wr(Base + 32'h1C, 4'hF, 32'hFFFF_FFFF);
        rd("noirq_0x18", Base + 32'h18, 32'h0);
        rd("noirq_0x1c", Base + 32'h1C, 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
